shift_arbiter: RTL

Shares one N-bit power-of-two multiplier (variable left shifter) among R requesters. Round-robin grant with valid/ready handshakes on every requester port and on the single result port. The result is registered and tagged with the requester ID and an overflow flag. Sits between several datapath clients and the shared shift resource, so no client duplicates the shifter.

---
 rtl/shift_arbiter_pkg.sv | 39 +++
 rtl/shift_arbiter_mul.sv | 15 +
 rtl/shift_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared types and the round-robin pick helper for shift_arbiter.
package shift_arbiter_pkg;

    // Result-register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Upper bound on requester count handled by rr_pick
    localparam int MAX_R = 32;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } pick_t;

    // First asserted valid bit scanning ptr, ptr+1, ... wrapping at nreq.
    // Loop bound is constant; the scan is iterated high-to-low so the
    // lowest offset from ptr is the one that sticks.
    function automatic pick_t rr_pick(input logic [MAX_R-1:0] valid,
                                      input int ptr, input int nreq);
        pick_t p;
        int    j;
        p = '0;
        for (int k = MAX_R - 1; k >= 0; k--) begin
            if (k < nreq) begin
                j = ptr + k;
                if (j >= nreq) j = j - nreq;
                if (valid[j]) begin
                    p.found = 1'b1;
                    p.idx   = 8'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/shift_arbiter_mul.sv
// Truncating multiply by 2**exp, i.e. a plain left shift kept to N bits.
module multiply_by_power_of_two
    import shift_arbiter_pkg::*;
#(
    parameter  int N  = 8,
    localparam int EW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [EW-1:0] exp_i,
    output logic [N-1:0]  product_o
);

    assign product_o = data_i << exp_i;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of one shared power-of-two multiplier.
// One-entry registered result with id and overflow tag.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int R  = 4,
    localparam int EW = $clog2(N),
    localparam int IW = $clog2(R)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_valid,
    output logic [R-1:0]         req_ready,
    input  logic [R-1:0][N-1:0]  req_data,
    input  logic [R-1:0][EW-1:0] req_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [IW-1:0]        out_id,
    output logic                 out_ovf
);

    state_t        state_q;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  data_q;
    logic [IW-1:0] id_q;
    logic          ovf_q;

    pick_t         pick;
    logic [IW-1:0] grant;
    logic          can_accept;
    logic          accept;
    logic [N-1:0]  sel_data;
    logic [EW-1:0] sel_exp;
    logic [EW-1:0] back_sh;
    logic [N-1:0]  lost;
    logic [N-1:0]  prod;
    logic          ovf_d;

    // Grant selection, ready generation and operand mux
    always_comb begin
        pick       = rr_pick(MAX_R'(req_valid), int'(ptr_q), R);
        grant      = '0;
        for (int i = 0; i < R; i++) begin
            if (pick.idx == 8'(i)) grant = IW'(i);
        end
        can_accept = (state_q == EMPTY) || out_ready;
        accept     = !rst && pick.found && can_accept;
        req_ready  = '0;
        if (accept) req_ready[grant] = 1'b1;
        sel_data   = req_data[grant];
        sel_exp    = req_exp[grant];
        ptr_d      = (grant == IW'(R - 1)) ? '0 : grant + IW'(1);
    end

    // Bits pushed past the top are data >> (N - exp); N - exp in EW bits
    // is just 0 - exp since N == 2**EW. exp == 0 would shift by N, so it
    // is excluded explicitly.
    always_comb begin
        back_sh = EW'(0) - sel_exp;
        lost    = (sel_exp == '0) ? '0 : (sel_data >> back_sh);
        ovf_d   = |lost;
    end

    multiply_by_power_of_two #(.N(N)) u_mul (
        .data_i    (sel_data),
        .exp_i     (sel_exp),
        .product_o (prod)
    );

    // EMPTY/FULL FSM, round-robin pointer and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            state_q <= FULL;
            ptr_q   <= ptr_d;
            data_q  <= prod;
            id_q    <= grant;
            ovf_q   <= ovf_d;
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_ovf   = ovf_q;

endmodule
